seg_scan_mux: RTL and testbench

- Time-multiplexed driver for a three-digit common-anode 7-segment display.
- Consumes the hundreds/tens/units BCD digits produced by the binary-to-BCD stage (the round-result byte).
- Drives one shared active-low segment bus plus three active-low digit enables.
- Adds snapshot double-buffering (no tearing), leading-zero blanking, PWM brightness and dead time between digits.

---
 rtl/disp_pkg.sv | 41 ++++
 rtl/bcd_seg_lut.sv | 27 ++
 rtl/seg_scan_mux.sv | 128 ++++++++++++
 tb/tb_seg_scan_mux.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Segment patterns are active-low, bit6=g ... bit0=a.
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [1:0] DIG_H = 2'd0;
  localparam logic [1:0] DIG_T = 2'd1;
  localparam logic [1:0] DIG_U = 2'd2;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd3_t;

  // Active-low enable for the digit selected by the scan index.
  function automatic logic [2:0] digit_enable(input logic [1:0] idx);
    logic [2:0] an;
    case (idx)
      DIG_H:   an = 3'b011;
      DIG_T:   an = 3'b101;
      DIG_U:   an = 3'b110;
      default: an = 3'b111;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/bcd_seg_lut.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_seg_lut
  import disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pattern lookup
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Three-digit common-anode display scanner with double-buffered digits,
// leading-zero blanking, PWM brightness and per-slot dead time.
module seg_scan_mux
  import disp_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV      = 16'd50000,
  parameter logic [7:0]  DEAD_CYC      = 8'd2,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  input  logic       load,
  input  logic [2:0] brightness,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_start,
  output logic       pending
);

  localparam logic [19:0] SLOT_EIGHTH = {4'd0, SCAN_DIV >> 3};

  logic [15:0] p_r;
  logic [1:0]  idx_r;
  bcd3_t       shadow_r;
  bcd3_t       active_r;
  logic        pending_r;
  logic [6:0]  seg_r;
  logic [2:0]  an_r;
  logic        frame_start_r;

  logic        slot_end_s;
  logic        swap_s;
  logic [19:0] thresh_s;
  logic [3:0]  digit_s;
  logic        blank_s;
  logic        lit_s;
  logic [6:0]  pat_s;

  assign slot_end_s = (p_r == (SCAN_DIV - 16'd1));
  assign swap_s     = slot_end_s && (idx_r == DIG_U) && pending_r;
  assign thresh_s   = ({17'd0, brightness} + 20'd1) * SLOT_EIGHTH;

  // Digit selection and leading-zero blanking for the current slot
  always_comb begin
    digit_s = active_r.units;
    blank_s = 1'b0;
    case (idx_r)
      DIG_H: begin
        digit_s = active_r.hundreds;
        blank_s = BLANK_LEADING && (active_r.hundreds == 4'd0);
      end
      DIG_T: begin
        digit_s = active_r.tens;
        blank_s = BLANK_LEADING && (active_r.hundreds == 4'd0) && (active_r.tens == 4'd0);
      end
      DIG_U: begin
        digit_s = active_r.units;
        blank_s = 1'b0;
      end
      default: begin
        digit_s = active_r.units;
        blank_s = 1'b1;
      end
    endcase
  end

  // Dead time at slot start, PWM cut-off at the brightness threshold
  assign lit_s = ({4'd0, p_r} >= {12'd0, DEAD_CYC}) && ({4'd0, p_r} < thresh_s) && !blank_s;

  bcd_seg_lut u_lut (
    .digit (digit_s),
    .seg   (pat_s)
  );

  // Slot prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r   <= 16'd0;
      idx_r <= DIG_H;
    end else if (slot_end_s) begin
      p_r   <= 16'd0;
      idx_r <= (idx_r == DIG_U) ? DIG_H : idx_r + 2'd1;
    end else begin
      p_r   <= p_r + 16'd1;
    end
  end

  // Shadow/active double buffer; a load coinciding with the swap stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r  <= '0;
      active_r  <= '0;
      pending_r <= 1'b0;
    end else begin
      if (swap_s) begin
        active_r <= shadow_r;
      end
      if (load) begin
        shadow_r  <= '{hundreds: hundreds, tens: tens, units: units};
        pending_r <= 1'b1;
      end else if (swap_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Registered display outputs, one cycle behind the scan position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r         <= SEG_BLANK;
      an_r          <= 3'b111;
      frame_start_r <= 1'b0;
    end else begin
      seg_r         <= lit_s ? pat_s : SEG_BLANK;
      an_r          <= lit_s ? digit_enable(idx_r) : 3'b111;
      frame_start_r <= (p_r == 16'd0) && (idx_r == DIG_H);
    end
  end

  assign seg         = seg_r;
  assign an          = an_r;
  assign frame_start = frame_start_r;
  assign pending     = pending_r;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench: a cycle-count reference model queues expected outputs,
// an independent monitor compares them after every rising edge.
module tb_seg_scan_mux;

  localparam int SD   = 16;
  localparam int DEAD = 2;
  localparam int FRAME = 3 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hundreds = 4'd0, tens = 4'd0, units = 4'd0;
  logic       load = 1'b0;
  logic [2:0] brightness = 3'd7;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_start, pending;

  seg_scan_mux #(.SCAN_DIV(16'd16), .DEAD_CYC(8'd2), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .hundreds(hundreds), .tens(tens), .units(units),
    .load(load), .brightness(brightness), .seg(seg), .an(an),
    .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] an;
    logic       fs;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state: cycles since reset, digit buffers, pending flag
  int         t = 0;
  logic [3:0] m_sh[3];
  logic [3:0] m_ac[3];
  bit         m_pend = 1'b0;

  function automatic logic [6:0] ref_pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic model_reset();
    t = 0;
    m_pend = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_sh[i] = 4'd0;
      m_ac[i] = 4'd0;
    end
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      load = 1'b0;
      model_reset();
      e.seg = 7'h7F; e.an = 3'b111; e.fs = 1'b0; e.pend = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input bit ld, input logic [3:0] h, input logic [3:0] tn,
                      input logic [3:0] u, input logic [2:0] br);
    int p, idx;
    bit blank, lit;
    exp_t e;
    @(negedge clk);
    rst = 1'b0; load = ld; hundreds = h; tens = tn; units = u; brightness = br;
    p   = t % SD;
    idx = (t / SD) % 3;
    if (idx == 0)      blank = (m_ac[0] == 4'd0);
    else if (idx == 1) blank = (m_ac[0] == 4'd0) && (m_ac[1] == 4'd0);
    else               blank = 1'b0;
    lit = (p >= DEAD) && (p < (int'(br) + 1) * (SD / 8)) && !blank;
    e.seg = lit ? ref_pat(m_ac[idx]) : 7'h7F;
    e.an  = lit ? (3'b111 & ~(3'b100 >> idx)) : 3'b111;
    e.fs  = (p == 0) && (idx == 0);
    if (idx == 2 && p == SD - 1 && m_pend) begin
      for (int i = 0; i < 3; i++) m_ac[i] = m_sh[i];
      m_pend = 1'b0;
    end
    if (ld) begin
      m_sh[0] = h; m_sh[1] = tn; m_sh[2] = u;
      m_pend = 1'b1;
    end
    e.pend = m_pend;
    exp_q.push_back(e);
    t++;
  endtask

  task automatic idle(input int n, input logic [2:0] br);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 4'd0, br);
  endtask

  // monitor: compare DUT outputs against the queued expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (seg !== e.seg || an !== e.an || frame_start !== e.fs || pending !== e.pend) begin
          miscompares++;
          $display("FAIL outputs @%0t: got seg=%b an=%b fs=%b pend=%b, want seg=%b an=%b fs=%b pend=%b",
                   $time, seg, an, frame_start, pending, e.seg, e.an, e.fs, e.pend);
        end
      end
    end
  end

  initial begin
    logic [2:0] br;
    logic [3:0] dh, dt, du;
    model_reset();
    do_reset(3);
    idle(2 * FRAME, 3'd7);

    step(1'b1, 4'd2, 4'd5, 4'd5, 3'd7);
    idle(2 * FRAME, 3'd7);

    step(1'b1, 4'd0, 4'd0, 4'd7, 3'd7);
    idle(FRAME + 10, 3'd7);
    step(1'b1, 4'd0, 4'd4, 4'd0, 3'd7);
    idle(2 * FRAME, 3'd7);

    step(1'b1, 4'd1, 4'd2, 4'd3, 3'd7);
    idle(FRAME, 3'd7);
    idle(2 * FRAME, 3'd1);

    step(1'b1, 4'd1, 4'd1, 4'd1, 3'd7);
    while ((t % FRAME) != FRAME - 1) step(1'b0, 4'd0, 4'd0, 4'd0, 3'd7);
    step(1'b1, 4'd9, 4'd9, 4'd9, 3'd7);
    idle(3 * FRAME, 3'd7);

    step(1'b1, 4'd1, 4'hC, 4'd5, 3'd7);
    idle(FRAME, 3'd7);
    while ((t % FRAME) != SD + 5) step(1'b0, 4'd0, 4'd0, 4'd0, 3'd7);
    step(1'b1, 4'd3, 4'd3, 4'd3, 3'd7);
    do_reset(2);
    idle(2 * FRAME, 3'd7);

    br = 3'd7;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset(1 + $urandom_range(0, 2));
      end else begin
        if ($urandom_range(0, 49) == 0) br = 3'($urandom_range(0, 7));
        dh = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dt = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        du = 4'($urandom_range(0, 15));
        step($urandom_range(0, 29) == 0, dh, dt, du, br);
      end
    end

    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
